alu_bist: RTL and testbench

- Built-in self-test master for the RCPU ALU; the driving and checking end of the ALU_OP/A/B -> F/ZF/OF interface.
- On `start`, it generates NUM_VECTORS pseudo-random operand pairs and cycles through all eight ALU operations.
- It drives the ALU, waits for the ALU to settle, and compares F/ZF/OF against an internal golden model.
- It reports pass/fail, an error count and the first failing vector. It sits beside the ALU in the RCPU datapath for bring-up and self-test.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_golden.sv | 49 ++++
 rtl/alu_bist.sv | 177 +++++++++++++++++
 tb/tb_alu_bist.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared ALU opcodes, BIST LFSR mask, FSM encoding and LFSR step.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_NOR = 3'b011;
   localparam logic [2:0] ALU_ADD = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b101;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_SLL = 3'b111;

   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_e;

   // Galois form: shift right, fold the mask in when a one falls out.
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      lfsr_step = v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_golden.sv
`default_nettype none
// ============================================================================
//  Module   : alu_golden
//  Brief    : Combinational reference ALU (op, A, B -> F, ZF, OF).
//  Revision : 1.0  initial release
// ============================================================================
module alu_golden
   import alu_pkg::*;
(
   input  logic [2:0]  alu_op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] f_o,
   output logic        zf_o,
   output logic        of_o
);

   logic [31:0] w_sum;
   logic [31:0] w_diff;

   assign w_sum  = a_i + b_i;
   assign w_diff = a_i - b_i;

   always_comb begin
      f_o  = '0;
      of_o = 1'b0;
      case (alu_op_i)
         ALU_AND: f_o = a_i & b_i;
         ALU_OR:  f_o = a_i | b_i;
         ALU_XOR: f_o = a_i ^ b_i;
         ALU_NOR: f_o = ~(a_i | b_i);
         ALU_ADD: begin
            f_o  = w_sum;
            of_o = (a_i[31] == b_i[31]) && (w_sum[31] != a_i[31]);
         end
         ALU_SUB: begin
            f_o  = w_diff;
            of_o = (a_i[31] != b_i[31]) && (w_diff[31] != a_i[31]);
         end
         ALU_SLT: f_o = {31'b0, ($signed(a_i) < $signed(b_i))};
         ALU_SLL: f_o = b_i << a_i[4:0];
         default: f_o = '0;
      endcase
   end

   assign zf_o = (f_o == 32'h0);

endmodule
`default_nettype wire

// File: rtl/alu_bist.sv
`default_nettype none
// ============================================================================
//  Module   : alu_bist
//  Brief    : ALU self-test master: LFSR operands, all ops, golden compare.
//  Revision : 1.0  initial release
// ============================================================================
module alu_bist
   import alu_pkg::*;
#(
   parameter int NUM_VECTORS   = 64,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] seed,
   output logic [2:0]  ALU_OP,
   output logic [31:0] A,
   output logic [31:0] B,
   input  logic [31:0] F,
   input  logic        ZF,
   input  logic        OF,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [15:0] first_err_idx,
   output logic [2:0]  first_err_op
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_e        state_q, state_d;
   logic [31:0]   lfsr_q, lfsr_d;
   logic [2:0]    op_q, op_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic [15:0]   err_q, err_d;
   logic [15:0]   ferr_idx_q, ferr_idx_d;
   logic [2:0]    ferr_op_q, ferr_op_d;
   logic [15:0]   idx_q, idx_d;
   logic [SW-1:0] wait_q, wait_d;

   logic [31:0]   w_gold_f;
   logic          w_gold_zf;
   logic          w_gold_of;
   logic          w_mismatch;

   alu_golden u_golden (
      .alu_op_i (op_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .f_o      (w_gold_f),
      .zf_o     (w_gold_zf),
      .of_o     (w_gold_of)
   );

   assign w_mismatch = ({F, ZF, OF} != {w_gold_f, w_gold_zf, w_gold_of});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         lfsr_q     <= 32'h1;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= '0;
         ferr_idx_q <= '0;
         ferr_op_q  <= '0;
         idx_q      <= '0;
         wait_q     <= '0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         ferr_idx_q <= ferr_idx_d;
         ferr_op_q  <= ferr_op_d;
         idx_q      <= idx_d;
         wait_q     <= wait_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      err_d      = err_q;
      ferr_idx_d = ferr_idx_q;
      ferr_op_d  = ferr_op_q;
      idx_d      = idx_q;
      wait_d     = wait_q;

      case (state_q)
         IDLE, DONE: begin
            // DONE publishes its result every cycle; a start overrides it below.
            if (state_q == DONE) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = (err_q == 16'h0);
            end
            if (start) begin
               state_d    = LOAD;
               lfsr_d     = (seed == 32'h0) ? 32'h1 : seed;
               err_d      = '0;
               ferr_idx_d = '0;
               ferr_op_d  = '0;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               idx_d      = '0;
               busy_d     = 1'b1;
            end
         end
         LOAD: begin
            a_d     = lfsr_q;
            b_d     = lfsr_step(lfsr_q);
            lfsr_d  = lfsr_step(lfsr_step(lfsr_q));
            op_d    = idx_q[2:0];
            wait_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (wait_q == SW'(SETTLE_CYCLES - 1)) begin
               state_d = CHECK;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         CHECK: begin
            if (w_mismatch) begin
               if (err_q != 16'hFFFF) begin
                  err_d = err_q + 16'd1;
               end
               if (err_q == 16'h0) begin
                  ferr_idx_d = idx_q;
                  ferr_op_d  = op_q;
               end
            end
            if (idx_q == 16'(NUM_VECTORS - 1)) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 16'd1;
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ALU_OP        = op_q;
   assign A             = a_q;
   assign B             = b_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_idx = ferr_idx_q;
   assign first_err_op  = ferr_op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_bist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_bist
//  Brief    : Self-checking bench for alu_bist with an attached (faultable) ALU.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_bist;

   localparam int NV  = 16;
   localparam int SC  = 1;
   localparam int PER = SC + 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] seed;
   logic [2:0]  alu_op;
   logic [31:0] a, b, f;
   logic        zf, ofl;
   logic        busy, done, pass;
   logic [15:0] err_count, first_err_idx;
   logic [2:0]  first_err_op;

   int checks     = 0;
   int failures   = 0;
   int fault_mode = 0;

   always #5 clk = ~clk;

   alu_bist #(.NUM_VECTORS(NV), .SETTLE_CYCLES(SC)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .seed          (seed),
      .ALU_OP        (alu_op),
      .A             (a),
      .B             (b),
      .F             (f),
      .ZF            (zf),
      .OF            (ofl),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_idx (first_err_idx),
      .first_err_op  (first_err_op)
   );

   // Arithmetic statement of the ALU: returns {F, ZF, OF}.
   function automatic logic [33:0] ref_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy, s;
      logic [31:0] r;
      logic o;
      sx = 64'($signed(x));
      sy = 64'($signed(y));
      s  = '0;
      o  = 1'b0;
      r  = '0;
      case (op)
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: r = x ^ y;
         3'd3: r = ~(x | y);
         3'd4: begin s = sx + sy; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         3'd5: begin s = sx - sy; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         3'd6: r = (sx < sy) ? 32'd1 : 32'd0;
         default: r = y << x[4:0];
      endcase
      return {r, (r == 32'h0), o};
   endfunction

   function automatic logic [31:0] step(input logic [31:0] l);
      return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
   endfunction

   // The ALU under test: correct, ADD forced to zero, or ZF inverted.
   always_comb begin
      logic [33:0] r;
      r   = ref_alu(alu_op, a, b);
      f   = r[33:2];
      zf  = r[1];
      ofl = r[0];
      if (fault_mode == 1 && alu_op == 3'b100) begin
         f  = '0;
         zf = 1'b1;
      end
      if (fault_mode == 2) zf = ~zf;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_run(input logic [31:0] sd, input int mode);
      logic [31:0] l, ea, eb;
      logic [2:0]  eop;
      logic [33:0] good;
      int exp_err, exp_fidx, exp_fop;
      fault_mode = mode;
      exp_err = 0; exp_fidx = 0; exp_fop = 0;
      l = (sd == 32'h0) ? 32'h1 : sd;
      start = 1'b1;
      seed  = sd;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("done_after_start", done, 0);
      chk("err_cleared", err_count, 0);
      for (int v = 0; v < NV; v++) begin
         @(posedge clk); #1;
         ea = l; l = step(l); eb = l; l = step(l);
         eop = 3'(v % 8);
         chk("load_op", alu_op, eop);
         chk("load_a", a, ea);
         chk("load_b", b, eb);
         good = ref_alu(eop, ea, eb);
         if (mode == 2 || (mode == 1 && eop == 3'd4 && good[33:2] != 32'h0)) begin
            if (exp_err == 0) begin exp_fidx = v; exp_fop = int'(eop); end
            exp_err++;
         end
         repeat (PER - 1) @(posedge clk);
         #1;
         chk("held_op", alu_op, eop);
         chk("held_a", a, ea);
         chk("held_b", b, eb);
         chk("done_low_in_run", done, 0);
      end
      @(posedge clk); #1;
      chk("done_rise", done, 1);
      chk("busy_fall", busy, 0);
      chk("pass", pass, (exp_err == 0) ? 1 : 0);
      chk("err_count", err_count, exp_err);
      chk("first_err_idx", first_err_idx, exp_fidx);
      chk("first_err_op", first_err_op, exp_fop);
      @(posedge clk); #1;
      chk("done_held", done, 1);
      chk("err_held", err_count, exp_err);
   endtask

   initial begin
      logic [31:0] sd, l, ea, eb;
      rst   = 1'b1;
      start = 1'b0;
      seed  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_op_a_b", {alu_op, a, b}, 0);
      chk("rst_err", {err_count, first_err_idx, first_err_op}, 0);
      @(negedge clk);
      rst = 1'b0;

      do_run(32'h1, 0);
      do_run(32'h0, 0);
      do_run(32'h1, 1);
      do_run($urandom, 1);
      do_run($urandom, 2);
      do_run($urandom, 0);

      // Re-start mid-run is ignored; reset mid-run clears everything at once.
      sd = $urandom | 32'h1;
      fault_mode = 0;
      start = 1'b1;
      seed  = sd;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1;
      seed  = ~sd;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      l = sd;
      for (int i = 0; i < 12; i++) l = step(l);
      ea = l;
      eb = step(l);
      chk("ignored_start_op", alu_op, 3'd6);
      chk("ignored_start_a", a, ea);
      chk("ignored_start_b", b, eb);
      chk("ignored_start_busy", busy, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_outputs", {busy, done, pass, alu_op, a, b}, 0);
      chk("abort_err", {err_count, first_err_idx, first_err_op}, 0);
      @(posedge clk); #1;
      chk("abort_idle", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      do_run($urandom, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
